// File: rtl/fir_stream_framer.sv
// Sample framer ahead of the FIR engine.
// It buffers upstream samples in a small circular FIFO and counts them against
// the programmed frame length. It marks the final sample with tlast. It also
// reports frame completion and rejected starts to the control logic.
//
// state | meaning
// IDLE  | no frame; upstream stalled; waiting for cfg_start
// RUN   | frame open; samples counted in, FIFO drains toward the FIR
// DONE  | last sample has left; one-cycle frame_done, then back to IDLE
module fir_stream_framer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic [31:0]              cfg_len,
    input  logic                     cfg_start,
    input  logic                     s_tvalid,
    input  logic [DW-1:0]            s_tdata,
    output logic                     s_tready,
    output logic                     m_tvalid,
    output logic [DW-1:0]            m_tdata,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     start_err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     len_r;
    logic [31:0]     in_cnt;
    logic [31:0]     out_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_r;
    logic            start_err_r;
    logic [DW:0]     mem [DEPTH];

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            last_in;
    logic [DW:0]     head;

    // Handshake and status decode; s_tready depends on registered state only
    always_comb begin
        full       = (level_r == LW'(DEPTH));
        empty      = (level_r == '0);
        s_tready   = (state == RUN) && (in_cnt < len_r) && !full;
        push       = s_tvalid && s_tready;
        pop        = !empty && m_tready;
        last_in    = (in_cnt == (len_r - 32'd1));
        head       = mem[rd_ptr];
        m_tvalid   = !empty;
        // Gating with empty keeps the data bus at zero while nothing is valid,
        // including right after reset when the storage holds unknown values.
        m_tdata    = empty ? '0 : head[DW-1:0];
        m_tlast    = !empty && head[DW];
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        start_err  = start_err_r;
        level      = level_r;
    end

    // FIFO storage write; contents are qualified by level, so no reset is needed
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_ptr] <= {last_in, s_tdata};
        end
    end

    // Frame FSM, counters and FIFO pointers
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state       <= IDLE;
            len_r       <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_r     <= '0;
            start_err_r <= 1'b0;
        end else begin
            start_err_r <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                in_cnt <= in_cnt + 32'd1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                out_cnt <= out_cnt + 32'd1;
            end

            case ({push, pop})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_len != 32'd0) begin
                            len_r   <= cfg_len;
                            in_cnt  <= '0;
                            out_cnt <= '0;
                            state   <= RUN;
                        end else begin
                            start_err_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cfg_start) begin
                        start_err_r <= 1'b1;
                    end
                    if (pop && head[DW]) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (cfg_start) begin
                        start_err_r <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fir_stream_framer.md
# fir_stream_framer

Frames the input sample stream ahead of the FIR engine in the axis clock domain. Sits between the Wishbone-to-AXI-Stream write path (the stream source) and the FIR engine's `ss_*` slave port. It buffers samples in a small FIFO, counts them against the programmed data length, and generates `tlast` on the final sample of each frame. It also reports frame completion and misuse to the control logic.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.
- `DW`, 32: sample width.

Ports:
- `axis_clk` in 1: sole clock. All logic is rising-edge.
- `axis_rst_n` in 1: reset, synchronous and active-low.
- `cfg_len` in 32: samples per frame. Sampled at `cfg_start`.
- `cfg_start` in 1: one-cycle start pulse from the control register.
- `s_tvalid` in 1: upstream sample valid.
- `s_tdata` in DW: upstream sample.
- `s_tready` out 1: framer accepts the sample.
- `m_tvalid` out 1: sample valid toward the FIR.
- `m_tdata` out DW: sample toward the FIR.
- `m_tlast` out 1: last sample of the frame.
- `m_tready` in 1: FIR accepts the sample.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse when the frame completes.
- `start_err` out 1: one-cycle pulse when a start is rejected.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
States: IDLE, RUN, DONE.

- **IDLE**
  - `s_tready` = 0.
  - On `cfg_start` with `cfg_len` ≠ 0: latch `len_r` = `cfg_len`, clear `in_cnt` and `out_cnt`, go to RUN.
  - On `cfg_start` with `cfg_len` = 0: pulse `start_err` and stay in IDLE.
- **RUN**
  - `s_tready` = (`in_cnt` < `len_r`) && !full.
  - Write handshake (`s_tvalid` && `s_tready`): push {last, data}, where last = (`in_cnt` == `len_r`−1); then `in_cnt`++.
  - Read handshake (`m_tvalid` && `m_tready`): pop the entry; `out_cnt`++.
  - A handshake whose entry has last = 1 sends the state to DONE.
- **DONE**
  - Lasts exactly one cycle: `frame_done` = 1, `s_tready` = 0, then go to IDLE.
- `cfg_start` in RUN or DONE: ignored, with `start_err` pulsed.
- Samples presented after `in_cnt` reaches `len_r` are stalled (`s_tready` = 0), never dropped or accepted.
- FIFO storage:
  - Circular buffer with `$clog2(DEPTH)`-bit read and write pointers that wrap at DEPTH−1 → 0.
  - Occupancy counter runs 0..DEPTH; full = (`level` == DEPTH), empty = (`level` == 0).
  - A simultaneous push and pop leaves `level` unchanged.
  - When full, a push is blocked even if a pop occurs in the same cycle (`s_tready` depends only on registered state).
- Outputs:
  - `m_tvalid` = !empty; `m_tdata` and `m_tlast` come from the head entry.
  - The FIFO drains in any state; it can only be non-empty in RUN.
- `busy` = (state ≠ IDLE).
- Counters are 32-bit. `len_r` up to 2^32−1 is legal, and no counter wraps inside a frame.

## Timing
- Reset: state = IDLE, pointers = 0, `level` = 0, counters = 0, `len_r` = 0. All outputs are 0, including `m_tdata`.
- Reset applied mid-frame discards the FIFO contents and counters at the next edge. No `frame_done` is generated.
- `cfg_start` at edge N → `busy` = 1 and `s_tready` may be 1 from N+1.
- Sample accepted at edge N → `m_tvalid` = 1 with that data from N+1. Minimum fall-through latency is 1 cycle.
- Sustained throughput is 1 sample/cycle when both sides are ready and the FIFO is neither full nor empty.
- `m_tvalid`, `m_tdata` and `m_tlast` hold stable while `m_tready` = 0.
- `s_tready` is registered-state-derived: no combinational path from `m_tready` or `s_tvalid`.
- Last sample popped at edge N → state = DONE during N+1 (`frame_done` = 1) → IDLE at N+2. A new `cfg_start` is accepted from N+2.

## Test plan
- **Basic frame.** Reset, then `cfg_len` = 3 with `cfg_start`; stream 0x11, 0x22, 0x33 with `m_tready` = 1.
  - Outputs appear 1 cycle after each accept, in order.
  - `m_tlast` = 1 only on 0x33.
  - `frame_done` pulses once, and `busy` falls 2 cycles after the last pop.
- **Backpressure/full.** `cfg_len` = 8, DEPTH = 4, `m_tready` = 0.
  - After 4 accepts: `level` = 4 and `s_tready` = 0.
  - Release `m_tready`: all 8 samples emerge in order, pointers wrap, `m_tlast` is on the 8th.
- **Over-supply.** `cfg_len` = 2, upstream holds `s_tvalid` = 1 with 3 samples.
  - Exactly 2 are accepted and the third stalls with `s_tready` = 0.
  - After DONE the FIFO is empty; the third sample is taken only after the next `cfg_start`.
- **Start errors.** `cfg_start` with `cfg_len` = 0 → `start_err` pulse, `busy` stays 0. `cfg_start` during RUN → `start_err` pulse, `len_r` unchanged.
- **Mid-frame reset.** `cfg_len` = 5, accept 3 samples, then `axis_rst_n` = 0 for 1 cycle.
  - Next cycle: `level` = 0, `m_tvalid` = 0, `busy` = 0, no `frame_done`.
  - A fresh frame with `cfg_len` = 1 works, with `m_tlast` = 1 on its only sample.
- **Simultaneous push/pop.** `cfg_len` = 16, `s_tvalid` and `m_tready` both held high.
  - `level` stays at 1 after the first sample.
  - One sample per cycle emerges, with `m_tlast` on the 16th.
